uart_tx_sched: RTL and testbench

//  Round-robin scheduler sharing one uart_tx byte transmitter among NREQ

---
 rtl/uart_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter that shares one byte-wide uart_tx among
// NREQ requesters. Level req/ack handshakes are turned into the transmitter's
// rising-edge send / busy protocol. A minimum idle gap is enforced between
// bytes, and a watchdog aborts a send that never sees busy.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-high
//   req          per-requester byte-pending level, held until matching ack
//   req_data     byte i at req_data[8*i+7:8*i], stable while req[i]
//   ack          one-cycle pulse when the granted byte finished or aborted
//   err_timeout  one-cycle pulse alongside ack on a watchdog abort
//   tx_send      to uart_tx send; rising edge starts a byte
//   tx_data      to uart_tx data_in; latched at grant
//   tx_busy      from uart_tx busy
//   active_id    index of the granted requester (valid when !idle)
//   idle         1 while the scheduler is in IDLE
module uart_tx_sched #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 8,
  parameter int unsigned GAP_CYC     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [8*NREQ-1:0]        req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     err_timeout,
  output logic                     tx_send,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(NREQ)-1:0]  active_id,
  output logic                     idle
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GW  = $clog2(GAP_CYC + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SEND      = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_GAP       = 2'd3;

  logic [1:0]      state,       state_d;
  logic [IDW-1:0]  rr_ptr,      rr_ptr_d;
  logic [TW-1:0]   tmo_cnt,     tmo_cnt_d;
  logic [GW-1:0]   gap_cnt,     gap_cnt_d;
  logic [NREQ-1:0] ack_d;
  logic            err_timeout_d;
  logic            tx_send_d;
  logic [7:0]      tx_data_d;
  logic [IDW-1:0]  active_id_d;
  logic            idle_d;

  logic            grant_valid;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  scan_idx;

  // Rotating priority search: first set req starting just after rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!grant_valid && req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d       = state;
    rr_ptr_d      = rr_ptr;
    tmo_cnt_d     = tmo_cnt;
    gap_cnt_d     = gap_cnt;
    ack_d         = '0;
    err_timeout_d = 1'b0;
    tx_send_d     = tx_send;
    tx_data_d     = tx_data;
    active_id_d   = active_id;

    case (state)
      S_IDLE: begin
        tx_send_d = 1'b0;
        if (grant_valid) begin
          state_d     = S_SEND;
          tx_send_d   = 1'b1;
          tx_data_d   = req_data[{grant_id, 3'b000} +: 8];
          active_id_d = grant_id;
          rr_ptr_d    = grant_id;
          tmo_cnt_d   = '0;
        end
      end
      S_SEND: begin
        if (tx_busy) begin
          tx_send_d = 1'b0;
          state_d   = S_WAIT_DONE;
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          // Watchdog: transmitter never acknowledged the send edge.
          tx_send_d     = 1'b0;
          ack_d         = NREQ'(1) << active_id;
          err_timeout_d = 1'b1;
          gap_cnt_d     = '0;
          state_d       = S_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        tx_send_d = 1'b0;
        if (!tx_busy) begin
          ack_d     = NREQ'(1) << active_id;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        // Keeps send low long enough that the next rising edge is seen.
        tx_send_d = 1'b0;
        if (gap_cnt == GW'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
        end
      end
      default: begin
        tx_send_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    idle_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= IDW'(NREQ - 1);
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      ack         <= '0;
      err_timeout <= 1'b0;
      tx_send     <= 1'b0;
      tx_data     <= '0;
      active_id   <= '0;
      idle        <= 1'b1;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      tmo_cnt     <= tmo_cnt_d;
      gap_cnt     <= gap_cnt_d;
      ack         <= ack_d;
      err_timeout <= err_timeout_d;
      tx_send     <= tx_send_d;
      tx_data     <= tx_data_d;
      active_id   <= active_id_d;
      idle        <= idle_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched with a behavioural uart_tx (busy 2 cycles after the
// send edge, BIT_CYC cycles per bit) and a line receiver.
module tb_uart_tx_sched;

  localparam int unsigned NREQ        = 4;
  localparam int unsigned TIMEOUT_CYC = 8;
  localparam int unsigned GAP_CYC     = 2;
  localparam int unsigned BIT_CYC     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        err_timeout;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  active_id;
  logic        idle;

  uart_tx_sched #(.NREQ(NREQ), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .err_timeout(err_timeout), .tx_send(tx_send), .tx_data(tx_data),
    .tx_busy(tx_busy), .active_id(active_id), .idle(idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural transmitter
  logic       uart_en;
  logic       u_busy, u_pend, send_q, line;
  logic [9:0] u_sh;
  logic [1:0] u_cnt;
  logic [3:0] u_bit;
  assign tx_busy = u_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      u_busy <= 1'b0; u_pend <= 1'b0; send_q <= 1'b0; line <= 1'b1;
      u_sh <= '0; u_cnt <= '0; u_bit <= '0;
    end else begin
      send_q <= tx_send;
      if (!u_busy && !u_pend && uart_en && tx_send && !send_q) begin
        u_pend <= 1'b1;
        u_sh   <= {1'b1, tx_data, 1'b0};
      end else if (u_pend) begin
        u_pend <= 1'b0; u_busy <= 1'b1; line <= u_sh[0];
        u_cnt <= '0; u_bit <= '0;
      end else if (u_busy) begin
        if (u_cnt == 2'(BIT_CYC - 1)) begin
          u_cnt <= '0;
          if (u_bit == 4'd9) begin
            u_busy <= 1'b0; line <= 1'b1;
          end else begin
            u_bit <= u_bit + 4'd1;
            line  <= u_sh[1];
            u_sh  <= {1'b1, u_sh[9:1]};
          end
        end else begin
          u_cnt <= u_cnt + 2'd1;
        end
      end
    end
  end

  // Line receiver: frame bit k = k-th bit seen on the line (bit0 = start)
  logic       r_act;
  logic [1:0] r_cnt;
  logic [3:0] r_bit;
  logic [8:0] r_frame;
  logic [9:0] rx_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act <= 1'b0; r_cnt <= '0; r_bit <= '0; r_frame <= '0;
    end else if (!r_act) begin
      if (!line) begin
        r_act <= 1'b1; r_cnt <= 2'd1; r_bit <= '0;
      end
    end else if (r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
    end else begin
      r_cnt <= 2'(BIT_CYC - 1);
      if (r_bit == 4'd9) begin
        rx_q.push_back({line, r_frame});
        r_act <= 1'b0;
      end else begin
        r_frame[r_bit] <= line;
        r_bit <= r_bit + 4'd1;
      end
    end
  end

  // Observation state
  int         tests = 0;
  int         fails = 0;
  logic [1:0] send_id_q[$];
  logic [7:0] send_data_q[$];
  int         send_cyc_q[$];
  int         send_gap_q[$];
  logic [3:0] ack_q[$];
  logic       err_q[$];
  int         n_acks;
  int         ack_bad;
  int         last_fall;
  logic       send_prev, busy_prev;
  logic [3:0] hold_mask, repulse_mask, rearm;

  task automatic clear_obs();
    send_id_q.delete(); send_data_q.delete(); send_cyc_q.delete();
    send_gap_q.delete(); ack_q.delete(); err_q.delete(); rx_q.delete();
    n_acks = 0; ack_bad = 0; last_fall = -1;
  endtask

  // One cycle: sample outputs at negedge, record events, act as requesters.
  task automatic tick();
    @(negedge clk);
    if (tx_send && !send_prev) begin
      send_id_q.push_back(active_id);
      send_data_q.push_back(tx_data);
      send_cyc_q.push_back(cyc);
      send_gap_q.push_back((last_fall < 0) ? 1000 : cyc - last_fall);
    end
    if (!tx_busy && busy_prev) last_fall = cyc;
    send_prev = tx_send;
    busy_prev = tx_busy;
    if (ack != 4'd0) begin
      ack_q.push_back(ack);
      err_q.push_back(err_timeout);
      n_acks++;
      if (((ack & (ack - 4'd1)) != 4'd0) || idle) ack_bad++;
    end
    if (err_timeout && ack == 4'd0) ack_bad++;
    req   = (req | rearm) & ~(ack & ~hold_mask);
    rearm = ack & repulse_mask;
  endtask

  task automatic do_reset();
    req = '0; hold_mask = '0; repulse_mask = '0; rearm = '0; uart_en = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int b;
    b = budget;
    while (n_acks < target && b > 0) begin
      tick();
      b--;
    end
    tests++;
    if (n_acks < target) begin
      fails++;
      $display("FAIL %s ack wait: got %0d acks, need %0d", name, n_acks, target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset idle: got %b want 1", idle); end
    tests++; if (tx_send !== 1'b0) begin fails++; $display("FAIL reset tx_send: got %b want 0", tx_send); end
    tests++; if (ack !== 4'd0) begin fails++; $display("FAIL reset ack: got %b want 0000", ack); end
    tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL reset err: got %b want 0", err_timeout); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset tx_data: got %h want 00", tx_data); end
    tests++; if (active_id !== 2'd0) begin fails++; $display("FAIL reset active_id: got %0d want 0", active_id); end
  endtask

  task automatic test_single();
    int start;
    do_reset();
    req_data = 32'h0000_00A5;
    req = 4'b0001;
    start = cyc;
    wait_acks(1, 200, "single");
    repeat (6) tick();
    tests++; if (send_cyc_q.size() != 1 || send_cyc_q[0] - start != 1) begin
      fails++; $display("FAIL single send latency: got %0d sends, latency %0d want 1", send_cyc_q.size(), (send_cyc_q.size() > 0) ? send_cyc_q[0] - start : -1); end
    tests++; if (rx_q.size() != 1 || rx_q[0] !== 10'b11_0100_1010) begin
      fails++; $display("FAIL single line frame: got %0d frames, first %b want 1101001010", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 10'h0); end
    tests++; if (ack_q.size() != 1 || ack_q[0] !== 4'b0001) begin
      fails++; $display("FAIL single ack: got %0d acks, first %b want 0001", ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : 4'h0); end
    tests++; if (err_q.size() != 1 || err_q[0] !== 1'b0) begin
      fails++; $display("FAIL single err: got err pulse where none expected"); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL single idle after: got %b want 1", idle); end
  endtask

  task automatic test_contention();
    do_reset();
    req_data = 32'h3332_3130;
    req = 4'b1111;
    wait_acks(4, 1000, "contention");
    repeat (8) tick();
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_b;
      logic [3:0] exp_a;
      exp_b = 8'h30 + 8'(k);
      exp_a = 4'b0001 << k;
      tests++; if (send_data_q.size() <= k || send_data_q[k] !== exp_b) begin
        fails++; $display("FAIL contention tx_data[%0d]: got %h want %h", k, (send_data_q.size() > k) ? send_data_q[k] : 8'h00, exp_b); end
      tests++; if (rx_q.size() <= k || rx_q[k][8:1] !== exp_b) begin
        fails++; $display("FAIL contention line byte[%0d]: got %h want %h", k, (rx_q.size() > k) ? rx_q[k][8:1] : 8'h00, exp_b); end
      tests++; if (ack_q.size() <= k || ack_q[k] !== exp_a) begin
        fails++; $display("FAIL contention ack[%0d]: got %b want %b", k, (ack_q.size() > k) ? ack_q[k] : 4'h0, exp_a); end
      if (k > 0) begin
        tests++; if (send_gap_q.size() <= k || send_gap_q[k] < int'(GAP_CYC + 1)) begin
          fails++; $display("FAIL contention gap[%0d]: got %0d cycles want >= %0d", k, (send_gap_q.size() > k) ? send_gap_q[k] : -1, GAP_CYC + 1); end
      end
    end
    tests++; if (ack_bad != 0) begin fails++; $display("FAIL contention ack shape: got %0d bad pulses want 0", ack_bad); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_id;
    do_reset();
    req_data = 32'h0022_0011;
    hold_mask = 4'b0001;
    repulse_mask = 4'b0100;
    req = 4'b0101;
    wait_acks(6, 1500, "fairness");
    for (int k = 0; k < 6; k++) begin
      exp_id = (k % 2 == 0) ? 2'd0 : 2'd2;
      tests++; if (send_id_q.size() <= k || send_id_q[k] !== exp_id) begin
        fails++; $display("FAIL fairness grant[%0d]: got %0d want %0d", k, (send_id_q.size() > k) ? send_id_q[k] : 2'd0, exp_id); end
    end
    tests++; if (ack_bad != 0) begin fails++; $display("FAIL fairness ack shape: got %0d bad pulses want 0", ack_bad); end
  endtask

  task automatic test_timeout();
    int   high;
    bit   fell;
    logic [3:0] ack_at;
    logic err_at;
    int   b;
    do_reset();
    uart_en = 1'b0;
    req_data = 32'h0000_7700;
    req = 4'b0010;
    high = 0; fell = 0; ack_at = '0; err_at = 1'b0;
    for (int i = 0; i < 60 && !fell; i++) begin
      tick();
      if (tx_send) high++;
      else if (high > 0) begin fell = 1; ack_at = ack; err_at = err_timeout; end
    end
    tests++; if (high != int'(TIMEOUT_CYC)) begin fails++; $display("FAIL timeout send width: got %0d cycles want %0d", high, TIMEOUT_CYC); end
    tests++; if (ack_at !== 4'b0010) begin fails++; $display("FAIL timeout ack: got %b want 0010", ack_at); end
    tests++; if (err_at !== 1'b1) begin fails++; $display("FAIL timeout err: got %b want 1", err_at); end
    b = 20;
    while (!idle && b > 0) begin tick(); b--; end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL timeout return idle: got %b want 1", idle); end
    uart_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int b;
    do_reset();
    req_data = 32'h0043_0041;
    req = 4'b0101;
    b = 60;
    while (!(tx_busy && !tx_send && !idle) && b > 0) begin tick(); b--; end
    tests++; if (!(tx_busy && !tx_send && !idle)) begin fails++; $display("FAIL resetmid reach wait_done: busy %b send %b idle %b", tx_busy, tx_send, idle); end
    repeat (3) tick();
    reset = 1'b1;
    #1;
    tests++; if (tx_send !== 1'b0) begin fails++; $display("FAIL resetmid tx_send: got %b want 0", tx_send); end
    tests++; if (ack !== 4'd0) begin fails++; $display("FAIL resetmid ack: got %b want 0000", ack); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL resetmid idle: got %b want 1", idle); end
    tick(); tick();
    tests++; if (ack_q.size() != 0) begin fails++; $display("FAIL resetmid no ack: got %0d acks want 0", ack_q.size()); end
    clear_obs();
    reset = 1'b0;
    wait_acks(2, 600, "resetmid");
    tests++; if (send_id_q.size() < 1 || send_id_q[0] !== 2'd0) begin
      fails++; $display("FAIL resetmid regrant id: got %0d want 0", (send_id_q.size() > 0) ? send_id_q[0] : 2'd3); end
    tests++; if (rx_q.size() < 1 || rx_q[0][8:1] !== 8'h41) begin
      fails++; $display("FAIL resetmid line byte: got %h want 41", (rx_q.size() > 0) ? rx_q[0][8:1] : 8'h00); end
    tests++; if (ack_q.size() != 2 || ack_q[0] !== 4'b0001 || ack_q[1] !== 4'b0100) begin
      fails++; $display("FAIL resetmid ack order: got %0d acks, want 0001 then 0100", ack_q.size()); end
  endtask

  task automatic test_data_change();
    int b;
    do_reset();
    req_data = 32'h0000_5C00;
    req = 4'b0010;
    b = 10;
    while (send_data_q.size() == 0 && b > 0) begin tick(); b--; end
    req_data[15:8] = 8'hFF;
    wait_acks(1, 200, "datachange");
    tests++; if (send_data_q.size() < 1 || send_data_q[0] !== 8'h5C) begin
      fails++; $display("FAIL datachange tx_data at send: got %h want 5C", (send_data_q.size() > 0) ? send_data_q[0] : 8'h00); end
    tests++; if (tx_data !== 8'h5C) begin fails++; $display("FAIL datachange tx_data held: got %h want 5C", tx_data); end
    repeat (4) tick();
    tests++; if (rx_q.size() < 1 || rx_q[0][8:1] !== 8'h5C) begin
      fails++; $display("FAIL datachange line byte: got %h want 5C", (rx_q.size() > 0) ? rx_q[0][8:1] : 8'h00); end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; uart_en = 1'b1;
    hold_mask = '0; repulse_mask = '0; rearm = '0;
    send_prev = 1'b0; busy_prev = 1'b0;
    clear_obs();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_data_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
